// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversampled MDC/MDIO, 32x16 register file, tristate read-back.
// Outputs update one CLK after the detected MDC rise; the bus has no backpressure, every MDC bit is consumed.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int          PRE_LEN  = 32,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        wr_valid,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data,
    output logic [7:0]  err_cnt
);
    localparam int              PW      = $clog2(PRE_LEN + 1);
    localparam logic [PW-1:0]   PRE_MAX = PW'(PRE_LEN);

    typedef enum logic [2:0] {
        S_PRE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t        state;
    logic [2:0]    mdc_sync;
    logic [1:0]    mdio_sync;
    logic          mdc_rise;
    logic          bit_in;
    logic [PW-1:0] pre_cnt;
    logic [3:0]    bit_cnt;
    logic          op_b0;
    logic          is_rd;
    logic          drive;
    logic [4:0]    phyad;
    logic [4:0]    regad;
    logic [15:0]   shreg;
    logic [15:0]   rf [32];
    logic          addr_hit;
    logic [15:0]   wdata;

    // mdc_sync[2] is the previous synchronized MDC, used only for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
        end else begin
            mdc_sync  <= {mdc_sync[1:0], mdc_i};
            mdio_sync <= {mdio_sync[0], mdio_i};
        end
    end

    assign mdc_rise = mdc_sync[1] & ~mdc_sync[2];
    assign bit_in   = mdio_sync[1];
    assign addr_hit = (phyad == PHY_ADDR);
    assign wdata    = {shreg[14:0], bit_in};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_PRE;
            pre_cnt  <= '0;
            bit_cnt  <= '0;
            op_b0    <= 1'b0;
            is_rd    <= 1'b0;
            drive    <= 1'b0;
            phyad    <= '0;
            regad    <= '0;
            shreg    <= '0;
            mdio_o   <= 1'b1;
            mdio_oe  <= 1'b0;
            wr_valid <= 1'b0;
            wr_regad <= '0;
            wr_data  <= '0;
            err_cnt  <= '0;
            for (int i = 0; i < 32; i++)
                rf[i] <= (i == 2) ? PHY_ID1 : (i == 3) ? PHY_ID2 : 16'h0000;
        end else begin
            wr_valid <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    S_PRE: begin
                        if (bit_in) begin
                            if (pre_cnt != PRE_MAX)
                                pre_cnt <= pre_cnt + PW'(1);
                        end else begin
                            if (pre_cnt == PRE_MAX)
                                state <= S_ST1;
                            pre_cnt <= '0;
                        end
                    end
                    S_ST1: begin
                        bit_cnt <= '0;
                        if (bit_in) begin
                            state <= S_OP;
                        end else begin
                            state <= S_PRE;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    S_OP: begin
                        op_b0 <= bit_in;
                        if (bit_cnt == 4'd1) begin
                            bit_cnt <= '0;
                            if (op_b0 != bit_in) begin
                                is_rd <= op_b0;
                                state <= S_PHYAD;
                            end else begin
                                state <= S_PRE;
                                if (err_cnt != 8'hFF)
                                    err_cnt <= err_cnt + 8'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_PHYAD: begin
                        phyad <= {phyad[3:0], bit_in};
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= '0;
                            state   <= S_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_REGAD: begin
                        regad <= {regad[3:0], bit_in};
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= '0;
                            state   <= S_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_TA: begin
                        // First TA edge: drive 0 for the second TA bit window.
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                            drive   <= is_rd && addr_hit;
                            if (is_rd && addr_hit) begin
                                mdio_oe <= 1'b1;
                                mdio_o  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                            shreg   <= rf[regad];
                            if (drive)
                                mdio_o <= rf[regad][15];
                        end
                    end
                    S_DATA: begin
                        shreg <= wdata;
                        if (drive)
                            mdio_o <= shreg[14];
                        if (bit_cnt == 4'd15) begin
                            state   <= S_PRE;
                            pre_cnt <= '0;
                            bit_cnt <= '0;
                            drive   <= 1'b0;
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b1;
                            if (!is_rd && addr_hit) begin
                                wr_valid <= 1'b1;
                                wr_regad <= regad;
                                wr_data  <= wdata;
                                if (regad != 5'd2 && regad != 5'd3)
                                    rf[regad] <= wdata;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: state <= S_PRE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed and randomized MDIO frames checked against a register-level model of the responder.
module tb_mdio_phy_responder;
    localparam logic [4:0] PHY = 5'd1;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        mdc_i = 1'b0;
    logic        mdio_i = 1'b1;
    logic        mdio_o;
    logic        mdio_oe;
    logic        wr_valid;
    logic [4:0]  wr_regad;
    logic [15:0] wr_data;
    logic [7:0]  err_cnt;

    mdio_phy_responder dut (
        .CLK(CLK), .RST_N(RST_N), .mdc_i(mdc_i), .mdio_i(mdio_i),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .wr_valid(wr_valid),
        .wr_regad(wr_regad), .wr_data(wr_data), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          wr_pulses = 0;
    logic [4:0]  last_regad = '0;
    logic [15:0] last_data = '0;
    logic [15:0] ref_rf [32];
    int          ref_err;

    always @(negedge CLK) begin
        if (wr_valid === 1'b1) begin
            wr_pulses++;
            last_regad = wr_regad;
            last_data  = wr_data;
        end
    end

    initial begin
        #950000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) ref_rf[i] = 16'h0000;
        ref_rf[2] = 16'h0141;
        ref_rf[3] = 16'h0CC2;
        ref_err = 0;
    endtask

    // One MDC period; DUT outputs are sampled just before the rising edge, as a master would.
    task automatic mbit(input logic b, output logic o, output logic oe);
        mdio_i = b;
        #77;
        o  = mdio_o;
        oe = mdio_oe;
        #3;
        mdc_i = 1'b1;
        #80;
        mdc_i = 1'b0;
    endtask

    task automatic frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                         input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                         input int abort_bit, output int oe_cnt, output logic [16:0] rd_bits);
        logic [31:0] body;
        logic o, oe;
        body = {st, op, pa, ra, 2'b10, wd};
        if (op == OP_RD) body[17:0] = '1;
        oe_cnt  = 0;
        rd_bits = '0;
        for (int i = 0; i < pre; i++) begin
            mbit(1'b1, o, oe);
            if (oe === 1'b1) oe_cnt++;
        end
        for (int i = 0; i < 32; i++) begin
            if (i == abort_bit) begin
                check("abort_oe_before", {31'd0, mdio_oe}, 32'd1);
                RST_N = 1'b0;
                #1;
                check("abort_oe", {31'd0, mdio_oe}, 32'd0);
                check("abort_o", {31'd0, mdio_o}, 32'd1);
                check("abort_err", {24'd0, err_cnt}, 32'd0);
                check("abort_regad", {27'd0, wr_regad}, 32'd0);
                check("abort_wdata", {16'd0, wr_data}, 32'd0);
                #29;
                RST_N = 1'b1;
                ref_reset();
                return;
            end
            mbit(body[31-i], o, oe);
            if (oe === 1'b1) oe_cnt++;
            if (i >= 15) rd_bits = {rd_bits[15:0], o};
        end
        mbit(1'b1, o, oe);
        if (oe === 1'b1) oe_cnt++;
    endtask

    task automatic xact(input string tag, input logic [1:0] op, input logic [4:0] pa,
                        input logic [4:0] ra, input logic [15:0] wd);
        int          p0;
        int          oe_cnt;
        logic [16:0] rd;
        p0 = wr_pulses;
        frame(32, 2'b01, op, pa, ra, wd, -1, oe_cnt, rd);
        if (op == OP_RD) begin
            if (pa == PHY) begin
                check({tag, "_oe17"}, oe_cnt, 17);
                check({tag, "_rdata"}, {15'd0, rd}, {16'd0, 1'b0, ref_rf[ra]});
            end else begin
                check({tag, "_oe0"}, oe_cnt, 0);
            end
            check({tag, "_nowr"}, wr_pulses, p0);
        end else if (op == OP_WR) begin
            check({tag, "_oe0"}, oe_cnt, 0);
            if (pa == PHY) begin
                check({tag, "_wrcnt"}, wr_pulses, p0 + 1);
                check({tag, "_wrregad"}, {27'd0, last_regad}, {27'd0, ra});
                check({tag, "_wrdata"}, {16'd0, last_data}, {16'd0, wd});
                if (ra != 5'd2 && ra != 5'd3) ref_rf[ra] = wd;
            end else begin
                check({tag, "_nowr"}, wr_pulses, p0);
            end
        end else begin
            if (ref_err < 255) ref_err++;
            check({tag, "_oe0"}, oe_cnt, 0);
            check({tag, "_nowr"}, wr_pulses, p0);
        end
        check({tag, "_err"}, {24'd0, err_cnt}, ref_err);
    endtask

    initial begin
        int          oe_cnt;
        int          p0;
        logic        o, oe;
        logic [16:0] rd;
        logic [1:0]  op;
        logic [4:0]  pa;

        ref_reset();
        #23;
        check("rst_oe", {31'd0, mdio_oe}, 32'd0);
        check("rst_o", {31'd0, mdio_o}, 32'd1);
        check("rst_wrv", {31'd0, wr_valid}, 32'd0);
        check("rst_regad", {27'd0, wr_regad}, 32'd0);
        check("rst_wdata", {16'd0, wr_data}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #7;

        xact("wr_r0", OP_WR, PHY, 5'd0, 16'h1140);
        xact("rd_r0", OP_RD, PHY, 5'd0, 16'h0000);
        xact("rd_r2", OP_RD, PHY, 5'd2, 16'h0000);
        xact("rd_r3", OP_RD, PHY, 5'd3, 16'h0000);
        xact("wr_r2", OP_WR, PHY, 5'd2, 16'hFFFF);
        xact("rd_r2b", OP_RD, PHY, 5'd2, 16'h0000);
        xact("wr_pa5", OP_WR, 5'd5, 5'd4, 16'hA5A5);
        xact("rd_r4", OP_RD, PHY, 5'd4, 16'h0000);

        // Short preamble: a 0 first breaks the run of ones left over from the previous frame.
        mbit(1'b0, o, oe);
        p0 = wr_pulses;
        frame(31, 2'b01, OP_RD, PHY, 5'd0, 16'h0000, -1, oe_cnt, rd);
        check("pre31_oe0", oe_cnt, 0);
        check("pre31_err", {24'd0, err_cnt}, ref_err);
        check("pre31_nowr", wr_pulses, p0);
        xact("rd_after31", OP_RD, PHY, 5'd0, 16'h0000);

        xact("op11", 2'b11, PHY, 5'd0, 16'h0000);
        frame(32, 2'b00, OP_RD, PHY, 5'd0, 16'h0000, -1, oe_cnt, rd);
        ref_err++;
        check("st00_oe0", oe_cnt, 0);
        check("st00_err", {24'd0, err_cnt}, ref_err);

        for (int n = 0; n < 28; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_RD;
                4, 5, 6, 7: op = OP_WR;
                8:          op = 2'b00;
                default:    op = 2'b11;
            endcase
            pa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            xact($sformatf("rnd%0d", n), op, pa, 5'($urandom_range(0, 31)), 16'($urandom));
        end

        xact("wr_r0_pre_abort", OP_WR, PHY, 5'd0, 16'hBEEF);
        frame(32, 2'b01, OP_RD, PHY, 5'd0, 16'h0000, 24, oe_cnt, rd);
        xact("rd_r0_post_rst", OP_RD, PHY, 5'd0, 16'h0000);
        xact("rd_r2_post_rst", OP_RD, PHY, 5'd2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
